// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of dmem_arbiter: one request (read or write) plus its read response.
// The requester holds the master modport, the arbiter the slave modport.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addrA;
    logic [ADDR_W-1:0] addrB;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rspValid;
    logic [DATA_W-1:0] rspDataA;
    logic [DATA_W-1:0] rspDataB;

    modport master (
        output valid, we, addrA, addrB, wdata,
        input  ready, rspValid, rspDataA, rspDataB
    );

    modport slave (
        input  valid, we, addrA, addrB, wdata,
        output ready, rspValid, rspDataA, rspDataB
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin controller for a 16x8 data memory with one write port and two
// combinational read ports; sweeps the memory to zero after reset or on clear_req.
module dmem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    dmem_arbiter_if.slave     req0,
    dmem_arbiter_if.slave     req1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr1,
    output logic [ADDR_W-1:0] mem_raddr2,
    input  logic [DATA_W-1:0] mem_rdata1,
    input  logic [DATA_W-1:0] mem_rdata2
);

    localparam logic [0:0]        ST_CLEAR  = 1'b0;
    localparam logic [0:0]        ST_SERVE  = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clearCnt;
    logic              lastGrant;
    logic              serving;
    logic              grant0;
    logic              grant1;
    logic              selWe;
    logic [ADDR_W-1:0] selAddrA;
    logic [ADDR_W-1:0] selAddrB;
    logic [DATA_W-1:0] selWdata;

    assign busy    = (state == ST_CLEAR);
    assign serving = (state == ST_SERVE) && !clear_req;

    // A lone requester always wins; on a tie the one that did not win last time goes.
    assign grant0 = serving && req0.valid && (!req1.valid || lastGrant);
    assign grant1 = serving && req1.valid && (!req0.valid || !lastGrant);

    assign req0.ready = grant0;
    assign req1.ready = grant1;

    always_comb begin
        selWe    = req0.we;
        selAddrA = req0.addrA;
        selAddrB = req0.addrB;
        selWdata = req0.wdata;
        if (grant1) begin
            selWe    = req1.we;
            selAddrA = req1.addrA;
            selAddrB = req1.addrB;
            selWdata = req1.wdata;
        end
    end

    // The clear sweep owns the write port; otherwise the granted requester drives the ports.
    always_comb begin
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_raddr1 = '0;
        mem_raddr2 = '0;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clearCnt;
        end else if (grant0 || grant1) begin
            if (selWe) begin
                mem_we    = 1'b1;
                mem_waddr = selAddrA;
                mem_wdata = selWdata;
            end else begin
                mem_raddr1 = selAddrA;
                mem_raddr2 = selAddrB;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_CLEAR;
            clearCnt  <= '0;
            lastGrant <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clearCnt <= clearCnt + 1'b1;
                    if (clearCnt == LAST_ADDR) begin
                        state <= ST_SERVE;
                    end
                end
                default: begin
                    if (clear_req) begin
                        state    <= ST_CLEAR;
                        clearCnt <= '0;
                    end
                end
            endcase
            if (grant0) begin
                lastGrant <= 1'b0;
            end else if (grant1) begin
                lastGrant <= 1'b1;
            end
        end
    end

    // Read data is captured at the end of the grant cycle and held until the next response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req0.rspValid <= 1'b0;
            req0.rspDataA <= '0;
            req0.rspDataB <= '0;
        end else begin
            req0.rspValid <= grant0 && !req0.we;
            if (grant0 && !req0.we) begin
                req0.rspDataA <= mem_rdata1;
                req0.rspDataB <= mem_rdata2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req1.rspValid <= 1'b0;
            req1.rspDataA <= '0;
            req1.rspDataB <= '0;
        end else begin
            req1.rspValid <= grant1 && !req1.we;
            if (grant1 && !req1.we) begin
                req1.rspDataA <= mem_rdata1;
                req1.rspDataB <= mem_rdata2;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural memory plus a reference model of memory contents,
// round-robin winner and held response data, driven by directed and random requests.
module tb_dmem_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          clearReq = 1'b0;
    logic          busy;
    logic          memWe;
    logic [AW-1:0] memWaddr;
    logic [DW-1:0] memWdata;
    logic [AW-1:0] memRaddr1;
    logic [AW-1:0] memRaddr2;
    logic [DW-1:0] memRdata1;
    logic [DW-1:0] memRdata2;

    logic [DW-1:0] memArr [16];
    logic [DW-1:0] refMem [16];
    logic [DW-1:0] expA [2];
    logic [DW-1:0] expB [2];
    int            mLast;
    int            checks = 0;
    int            errors = 0;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clearReq),
        .busy      (busy),
        .req0      (bus0),
        .req1      (bus1),
        .mem_we    (memWe),
        .mem_waddr (memWaddr),
        .mem_wdata (memWdata),
        .mem_raddr1(memRaddr1),
        .mem_raddr2(memRaddr2),
        .mem_rdata1(memRdata1),
        .mem_rdata2(memRdata2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memWe) memArr[memWaddr] <= memWdata;
    end
    assign memRdata1 = memArr[memRaddr1];
    assign memRdata2 = memArr[memRaddr2];

    task automatic modelClear();
        for (int i = 0; i < 16; i++) refMem[i] = '0;
    endtask

    task automatic setReq(input int who, input logic v, input logic we,
                          input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [DW-1:0] wd);
        if (who == 0) begin
            bus0.valid = v; bus0.we = we; bus0.addrA = a; bus0.addrB = b; bus0.wdata = wd;
        end else begin
            bus1.valid = v; bus1.we = we; bus1.addrA = a; bus1.addrB = b; bus1.wdata = wd;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-requester transaction; returns one step after the accepting edge.
    task automatic issue(input int who, input logic we, input logic [AW-1:0] a,
                         input logic [AW-1:0] b, input logic [DW-1:0] wd,
                         output bit granted, output int lat);
        setReq(who, 1'b1, we, a, b, wd);
        granted = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !granted; i++) begin
            #1;
            if ((who == 0) ? bus0.ready : bus1.ready) begin
                granted = 1'b1;
                mLast = who;
                if (we) refMem[a] = wd;
                else begin
                    expA[who] = refMem[a];
                    expB[who] = refMem[b];
                end
            end else lat++;
            step();
        end
        setReq(who, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        bit g; int lat;
        reset = 1'b0;
        setReq(0, 1'b1, 1'b0, 4'd3, 4'd4, 8'h00);
        setReq(1, 1'b1, 1'b1, 4'd5, 4'd0, 8'h22);
        step(); step();
        checks++;
        if (busy !== 1'b1 || bus0.ready !== 1'b0 || bus1.ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl: busy=%b rdy0=%b rdy1=%b, required 1 0 0", busy, bus0.ready, bus1.ready);
        end
        checks++;
        if (bus0.rspValid !== 1'b0 || bus0.rspDataA !== 8'h00 || bus0.rspDataB !== 8'h00 ||
            bus1.rspValid !== 1'b0 || bus1.rspDataA !== 8'h00 || bus1.rspDataB !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_rsp: v0=%b %h %h v1=%b %h %h, required all zero", bus0.rspValid,
                               bus0.rspDataA, bus0.rspDataB, bus1.rspValid, bus1.rspDataA, bus1.rspDataB);
        end
        reset = 1'b1;
        modelClear();
        mLast = 1;
        expA[0] = '0; expB[0] = '0; expA[1] = '0; expB[1] = '0;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || memWe !== 1'b1 || memWaddr !== 4'(i) || memWdata !== 8'h00 ||
                bus0.ready !== 1'b0 || bus1.ready !== 1'b0) begin
                errors++; $display("[TB] FAIL sweep_%0d: busy=%b we=%b waddr=%0d wdata=%h rdy=%b%b, required 1 1 %0d 00 00",
                                   i, busy, memWe, memWaddr, memWdata, bus0.ready, bus1.ready, i);
            end
            step();
        end
        setReq(0, 1'b0, 1'b0, '0, '0, '0);
        setReq(1, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL serve_busy: busy=%b, required 0", busy);
        end
        issue(1, 1'b0, 4'd5, 4'd15, 8'h00, g, lat);
        checks++;
        if (!g || bus1.rspValid !== 1'b1 || bus1.rspDataA !== expA[1] || bus1.rspDataB !== expB[1]) begin
            errors++; $display("[TB] FAIL reset_read: g=%b v=%b a=%h b=%h, required 1 1 %h %h", g, bus1.rspValid,
                               bus1.rspDataA, bus1.rspDataB, expA[1], expB[1]);
        end
    endtask

    task automatic test_alternate();
        logic          we0 [2]; logic [AW-1:0] aa0 [2]; logic [AW-1:0] ab0 [2]; logic [DW-1:0] wd0 [2];
        logic          we1 [2]; logic [AW-1:0] aa1 [2]; logic [AW-1:0] ab1 [2]; logic [DW-1:0] wd1 [2];
        int order [4];
        int idx0, idx1, rd;
        we0 = '{1'b1, 1'b0}; aa0 = '{4'd2, 4'd2}; ab0 = '{4'd0, 4'd4}; wd0 = '{8'hA5, 8'h00};
        we1 = '{1'b1, 1'b0}; aa1 = '{4'd4, 4'd4}; ab1 = '{4'd0, 4'd2}; wd1 = '{8'h3C, 8'h00};
        order = '{0, 1, 0, 1};
        idx0 = 0; idx1 = 0;
        for (int g = 0; g < 4; g++) begin
            if (idx0 < 2) setReq(0, 1'b1, we0[idx0], aa0[idx0], ab0[idx0], wd0[idx0]);
            else setReq(0, 1'b0, 1'b0, '0, '0, '0);
            if (idx1 < 2) setReq(1, 1'b1, we1[idx1], aa1[idx1], ab1[idx1], wd1[idx1]);
            else setReq(1, 1'b0, 1'b0, '0, '0, '0);
            #1;
            checks++;
            if (bus0.ready !== (order[g] == 0) || bus1.ready !== (order[g] == 1)) begin
                errors++; $display("[TB] FAIL alt_grant_%0d: rdy0=%b rdy1=%b, required winner %0d", g,
                                   bus0.ready, bus1.ready, order[g]);
            end
            rd = -1;
            if (order[g] == 0 && idx0 < 2) begin
                if (we0[idx0]) refMem[aa0[idx0]] = wd0[idx0];
                else begin expA[0] = refMem[aa0[idx0]]; expB[0] = refMem[ab0[idx0]]; rd = 0; end
                idx0++;
            end else if (order[g] == 1 && idx1 < 2) begin
                if (we1[idx1]) refMem[aa1[idx1]] = wd1[idx1];
                else begin expA[1] = refMem[aa1[idx1]]; expB[1] = refMem[ab1[idx1]]; rd = 1; end
                idx1++;
            end
            mLast = order[g];
            step();
            if (rd == 0) begin
                checks++;
                if (bus0.rspValid !== 1'b1 || bus0.rspDataA !== expA[0] || bus0.rspDataB !== expB[0]) begin
                    errors++; $display("[TB] FAIL alt_read0: v=%b a=%h b=%h, required 1 %h %h", bus0.rspValid,
                                       bus0.rspDataA, bus0.rspDataB, expA[0], expB[0]);
                end
            end else if (rd == 1) begin
                checks++;
                if (bus1.rspValid !== 1'b1 || bus1.rspDataA !== expA[1] || bus1.rspDataB !== expB[1]) begin
                    errors++; $display("[TB] FAIL alt_read1: v=%b a=%h b=%h, required 1 %h %h", bus1.rspValid,
                                       bus1.rspDataA, bus1.rspDataB, expA[1], expB[1]);
                end
            end
        end
        setReq(0, 1'b0, 1'b0, '0, '0, '0);
        setReq(1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_write_read();
        bit g; int lat;
        issue(0, 1'b1, 4'd0, 4'd0, 8'h11, g, lat);
        checks++;
        if (!g || bus0.rspValid !== 1'b0) begin
            errors++; $display("[TB] FAIL write_norsp: g=%b v=%b, required 1 0", g, bus0.rspValid);
        end
        issue(0, 1'b0, 4'd0, 4'd3, 8'h00, g, lat);
        checks++;
        if (!g || lat != 0 || bus0.rspValid !== 1'b1 || bus0.rspDataA !== 8'h11 || bus0.rspDataB !== 8'h00) begin
            errors++; $display("[TB] FAIL read_rsp: g=%b lat=%0d v=%b a=%h b=%h, required 1 0 1 11 00", g, lat,
                               bus0.rspValid, bus0.rspDataA, bus0.rspDataB);
        end
        step();
        checks++;
        if (bus0.rspValid !== 1'b0 || bus0.rspDataA !== 8'h11 || bus0.rspDataB !== 8'h00) begin
            errors++; $display("[TB] FAIL rsp_pulse: v=%b a=%h b=%h, required 0 11 00", bus0.rspValid,
                               bus0.rspDataA, bus0.rspDataB);
        end
    endtask

    task automatic test_raw();
        bit g; int lat;
        issue(1, 1'b1, 4'd7, 4'd0, 8'h71, g, lat);
        issue(0, 1'b0, 4'd7, 4'd2, 8'h00, g, lat);
        checks++;
        if (!g || lat != 0 || bus0.rspValid !== 1'b1 || bus0.rspDataA !== 8'h71 || bus0.rspDataB !== expB[0]) begin
            errors++; $display("[TB] FAIL raw: g=%b lat=%0d v=%b a=%h b=%h, required 1 0 1 71 %h", g, lat,
                               bus0.rspValid, bus0.rspDataA, bus0.rspDataB, expB[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] wd;
        for (int i = 0; i < 16; i++) begin
            wd = 8'($urandom_range(1, 255));
            if (i < 8) setReq(0, 1'b1, 1'b1, 4'(i + 8), 4'd0, wd);
            else setReq(0, 1'b1, 1'b0, 4'(i), 4'(15 - i), 8'h00);
            #1;
            checks++;
            if (bus0.ready !== 1'b1) begin
                errors++; $display("[TB] FAIL b2b_ready_%0d: rdy=%b, required 1", i, bus0.ready);
            end
            mLast = 0;
            if (i < 8) refMem[4'(i + 8)] = wd;
            else begin expA[0] = refMem[4'(i)]; expB[0] = refMem[4'(15 - i)]; end
            step();
            if (i >= 8) begin
                checks++;
                if (bus0.rspValid !== 1'b1 || bus0.rspDataA !== expA[0] || bus0.rspDataB !== expB[0]) begin
                    errors++; $display("[TB] FAIL b2b_read_%0d: v=%b a=%h b=%h, required 1 %h %h", i, bus0.rspValid,
                                       bus0.rspDataA, bus0.rspDataB, expA[0], expB[0]);
                end
            end
        end
        setReq(0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_random();
        bit pv [2]; logic pwe [2]; logic [AW-1:0] pa [2]; logic [AW-1:0] pb [2]; logic [DW-1:0] pwd [2];
        bit e [2]; bit er [2]; bit anyGrant; logic expWe;
        pv = '{1'b0, 1'b0};
        for (int c = 0; c < 300; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && $urandom_range(0, 2) != 0) begin
                    pv[r] = 1'b1;
                    pwe[r] = 1'($urandom_range(0, 1));
                    pa[r] = 4'($urandom_range(0, 15));
                    pb[r] = 4'($urandom_range(0, 15));
                    pwd[r] = 8'($urandom_range(1, 255));
                end
                if (pv[r]) setReq(r, 1'b1, pwe[r], pa[r], pb[r], pwd[r]);
                else setReq(r, 1'b0, 1'b0, '0, '0, '0);
            end
            #1;
            e[0] = pv[0] && (!pv[1] || mLast == 1);
            e[1] = pv[1] && (!pv[0] || mLast == 0);
            checks++;
            if (bus0.ready !== e[0] || bus1.ready !== e[1]) begin
                errors++; $display("[TB] FAIL rand_grant_%0d: rdy=%b%b, required %b%b", c, bus0.ready, bus1.ready, e[0], e[1]);
            end
            anyGrant = e[0] || e[1];
            expWe = (e[0] && pwe[0]) || (e[1] && pwe[1]);
            checks++;
            if (memWe !== expWe || (!anyGrant && (memWaddr !== 4'd0 || memRaddr1 !== 4'd0 ||
                                                  memRaddr2 !== 4'd0 || memWdata !== 8'h00))) begin
                errors++; $display("[TB] FAIL rand_memport_%0d: we=%b wa=%0d r1=%0d r2=%0d wd=%h, required we=%b", c,
                                   memWe, memWaddr, memRaddr1, memRaddr2, memWdata, expWe);
            end
            for (int r = 0; r < 2; r++) begin
                er[r] = e[r] && !pwe[r];
                if (e[r]) begin
                    mLast = r;
                    if (pwe[r]) refMem[pa[r]] = pwd[r];
                    else begin expA[r] = refMem[pa[r]]; expB[r] = refMem[pb[r]]; end
                    pv[r] = 1'b0;
                end
            end
            step();
            checks++;
            if (bus0.rspValid !== er[0] || bus0.rspDataA !== expA[0] || bus0.rspDataB !== expB[0] ||
                bus1.rspValid !== er[1] || bus1.rspDataA !== expA[1] || bus1.rspDataB !== expB[1]) begin
                errors++; $display("[TB] FAIL rand_rsp_%0d: v0=%b %h %h v1=%b %h %h, required %b %h %h %b %h %h", c,
                                   bus0.rspValid, bus0.rspDataA, bus0.rspDataB, bus1.rspValid, bus1.rspDataA,
                                   bus1.rspDataB, er[0], expA[0], expB[0], er[1], expA[1], expB[1]);
            end
        end
        setReq(0, 1'b0, 1'b0, '0, '0, '0);
        setReq(1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_clear();
        bit g; int lat;
        for (int i = 0; i < 16; i++) issue(i % 2, 1'b1, 4'(i), 4'd0, 8'(i + 1), g, lat);
        clearReq = 1'b1;
        setReq(0, 1'b1, 1'b0, 4'd0, 4'd15, 8'h00);
        #1;
        checks++;
        if (bus0.ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL clear_req_cycle: rdy=%b busy=%b, required 0 0", bus0.ready, busy);
        end
        step();
        clearReq = 1'b0;
        modelClear();
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || bus0.ready !== 1'b0 || memWe !== 1'b1 || memWaddr !== 4'(i) || memWdata !== 8'h00) begin
                errors++; $display("[TB] FAIL clear_sweep_%0d: busy=%b rdy=%b we=%b wa=%0d wd=%h, required 1 0 1 %0d 00",
                                   i, busy, bus0.ready, memWe, memWaddr, memWdata, i);
            end
            step();
        end
        #1;
        checks++;
        if (busy !== 1'b0 || bus0.ready !== 1'b1) begin
            errors++; $display("[TB] FAIL clear_done: busy=%b rdy=%b, required 0 1", busy, bus0.ready);
        end
        mLast = 0;
        expA[0] = refMem[0]; expB[0] = refMem[15];
        step();
        setReq(0, 1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (bus0.rspValid !== 1'b1 || bus0.rspDataA !== 8'h00 || bus0.rspDataB !== 8'h00) begin
            errors++; $display("[TB] FAIL clear_read: v=%b a=%h b=%h, required 1 00 00", bus0.rspValid,
                               bus0.rspDataA, bus0.rspDataB);
        end
    endtask

    task automatic test_reset_mid();
        bit g; int lat;
        issue(1, 1'b1, 4'd3, 4'd0, 8'h5A, g, lat);
        setReq(0, 1'b1, 1'b0, 4'd3, 4'd3, 8'h00);
        #1;
        checks++;
        if (bus0.ready !== 1'b1) begin
            errors++; $display("[TB] FAIL mid_grant: rdy=%b, required 1", bus0.ready);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || bus0.ready !== 1'b0 || bus0.rspValid !== 1'b0 || bus0.rspDataA !== 8'h00) begin
            errors++; $display("[TB] FAIL mid_reset: busy=%b rdy=%b v=%b a=%h, required 1 0 0 00", busy,
                               bus0.ready, bus0.rspValid, bus0.rspDataA);
        end
        step();
        setReq(0, 1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (bus0.rspValid !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_norsp: v=%b, required 0", bus0.rspValid);
        end
        reset = 1'b1;
        modelClear();
        mLast = 1;
        expA[0] = '0; expB[0] = '0; expA[1] = '0; expB[1] = '0;
        #1;
        checks++;
        if (memWe !== 1'b1 || memWaddr !== 4'd0) begin
            errors++; $display("[TB] FAIL mid_sweep0: we=%b wa=%0d, required 1 0", memWe, memWaddr);
        end
        step();
        checks++;
        if (memWaddr !== 4'd1 || busy !== 1'b1 || bus0.rspValid !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_sweep1: wa=%0d busy=%b v=%b, required 1 1 0", memWaddr, busy, bus0.rspValid);
        end
        repeat (15) step();
        issue(0, 1'b0, 4'd3, 4'd8, 8'h00, g, lat);
        checks++;
        if (!g || bus0.rspValid !== 1'b1 || bus0.rspDataA !== 8'h00 || bus0.rspDataB !== 8'h00) begin
            errors++; $display("[TB] FAIL mid_readback: g=%b v=%b a=%h b=%h, required 1 1 00 00", g,
                               bus0.rspValid, bus0.rspDataA, bus0.rspDataB);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        setReq(0, 1'b0, 1'b0, '0, '0, '0);
        setReq(1, 1'b0, 1'b0, '0, '0, '0);
        mLast = 1;
        test_reset();
        test_alternate();
        test_write_read();
        test_raw();
        test_back_to_back();
        test_random();
        test_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller that owns the 16x8 data memory (one write port, two combinational read ports).
- Clears the memory after reset or on command.
- Round-robin arbitration gives one requester per cycle access to the memory ports.
- Returns registered read data with a one-cycle valid pulse.
- Sits between the processor/loader requesters and the data memory instance.

Parameters:
- ADDR_W, 4, memory address width; depth is 2**ADDR_W.
- DATA_W, 8, memory word width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear_req  in  1  one-cycle pulse; re-runs the memory clear sweep.
- busy  out  1  high while clearing.
- req0_valid  in  1  requester 0 transaction valid.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr_a  in  ADDR_W  write address, or read address A.
- req0_addr_b  in  ADDR_W  read address B.
- req0_wdata  in  DATA_W  write data.
- req0_ready  out  1  grant; transfer occurs when valid&&ready.
- rsp0_valid  out  1  read response valid pulse.
- rsp0_data_a  out  DATA_W  read data from addr_a.
- rsp0_data_b  out  DATA_W  read data from addr_b.
- req1_*, rsp1_*  same set as requester 0, for requester 1.
- mem_we  out  1  memory write enable.
- mem_waddr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- mem_raddr1  out  ADDR_W  memory read address 1.
- mem_raddr2  out  ADDR_W  memory read address 2.
- mem_rdata1  in  DATA_W  combinational read data for mem_raddr1.
- mem_rdata2  in  DATA_W  combinational read data for mem_raddr2.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=CLEAR, clear counter=0, last_grant=1 (so requester 0 wins the first tie).
  - rsp*_valid=0, rsp*_data_*=0.
  - A transaction in progress is dropped; no response is issued for it.
- State CLEAR:
  - busy=1, req0_ready=req1_ready=0.
  - mem_we=1, mem_waddr=counter, mem_wdata=0, mem_raddr1=mem_raddr2=0.
  - Counter increments each cycle. After the cycle with counter=2**ADDR_W-1 (16 cycles total), move to SERVE; counter wraps to 0.
  - clear_req is ignored during CLEAR.
- State SERVE:
  - busy=0.
  - clear_req=1 → CLEAR next cycle, counter=0. No grant is issued in that cycle.
- Arbitration in SERVE (combinational, same cycle):
  - Only req0_valid high → grant 0. Only req1_valid high → grant 1.
  - Both high → grant the requester not in last_grant.
  - last_grant updates on each granted cycle; it holds when there is no grant.
- A requester holds all req fields stable until it sees ready. ready is only high in a cycle where the same requester's valid is high.
- Granted write:
  - mem_we=1, mem_waddr=addr_a, mem_wdata=wdata; the memory commits at the next rising edge.
  - No response is issued for a write.
- Granted read:
  - mem_we=0, mem_raddr1=addr_a, mem_raddr2=addr_b.
  - mem_rdata1/2 are captured at the rising edge that ends the grant cycle.
  - rsp_valid=1 for exactly the following cycle, with the captured data.
  - rsp_data holds its value after the valid pulse until the next response to that requester.
- No grant: mem_we=0, all mem addresses=0, mem_wdata=0.
- Read-after-write: a write granted in cycle N is visible to a read granted in cycle N+1 or later.
- Back-to-back: a requester holding valid with no competition is granted every cycle (throughput 1 per cycle).
- Latency: write completes at the grant-cycle edge; read response arrives 1 cycle after grant.

Test Plan:
- Reset release: 16 cycles with busy=1 and mem_we=1 writing 0 to addresses 0..15. First SERVE cycle has busy=0; reading addr 5/addr 15 returns 0x00/0x00.
- Req0 writes 0x11 to addr 0, then reads addr_a=0, addr_b=3 → rsp0_valid is high for one cycle, 1 cycle after grant, with data_a=0x11 and data_b=0x00.
- Both requesters valid continuously: req0 writes 0xA5 to addr 2, req1 writes 0x3C to addr 4 → grants alternate 0,1,0,1 starting with 0. Final reads return 0xA5 and 0x3C.
- Req1 writes 0x71 to addr 7 in cycle N, req0 reads addr 7 in cycle N+1 → rsp0_data_a=0x71.
- After filling all 16 addresses with nonzero data, pulse clear_req → busy high for 16 cycles with no ready. Subsequent reads of addr 0 and addr 15 return 0x00.
- Assert reset low mid-read-grant (asynchronously, between edges) → rsp0_valid stays 0 and the clear sweep restarts at address 0.
